// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (instruction/data) arbiter for a single RAM port,
//               with bounded instruction starvation under data pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramrdy
);

  localparam int c_cnt_w = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_addr;
  logic [31:0]        r_store;
  logic               r_wr;
  logic               r_ren;
  logic               r_wen;
  logic [c_cnt_w-1:0] r_starve;

  logic               w_dreq;
  logic               w_dgrant;
  logic               w_done;
  logic               w_icomp;
  logic               w_dcomp;

  assign w_dreq   = dREN | dWEN;
  assign w_dgrant = w_dreq && ((r_starve < c_cnt_w'(STARVE_MAX)) || !iREN);

  // A completion coinciding with a reset edge is suppressed so the aborted
  // access never shows a wait-low pulse.
  assign w_done  = ramrdy && !RST;
  assign w_icomp = (r_state == IACC) && w_done;
  assign w_dcomp = (r_state == DACC) && w_done;

  assign iwait = iREN && !w_icomp;
  assign dwait = w_dreq && !w_dcomp;
  assign iload = (w_icomp && iREN) ? ramload : 32'd0;
  assign dload = (w_dcomp && w_dreq && !r_wr) ? ramload : 32'd0;

  assign ramREN   = r_ren;
  assign ramWEN   = r_wen;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_addr   <= 32'd0;
      r_store  <= 32'd0;
      r_wr     <= 1'b0;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_starve <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dgrant) begin
            r_state <= DACC;
            r_addr  <= daddr;
            r_store <= dstore;
            r_wr    <= dWEN;
            r_ren   <= !dWEN;
            r_wen   <= dWEN;
            if (!iREN) begin
              r_starve <= '0;
            end else if (r_starve != c_cnt_w'(STARVE_MAX)) begin
              r_starve <= r_starve + c_cnt_w'(1);
            end
          end else if (iREN) begin
            r_state  <= IACC;
            r_addr   <= iaddr;
            r_store  <= 32'd0;
            r_wr     <= 1'b0;
            r_ren    <= 1'b1;
            r_wen    <= 1'b0;
            r_starve <= '0;
          end
        end
        IACC, DACC: begin
          // Wait as long as the RAM needs; the requester may vanish meanwhile.
          if (ramrdy) begin
            r_state <= IDLE;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ren   <= 1'b0;
          r_wen   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Randomized scoreboard bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] dstore = 32'd0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = 32'd0;
  logic        ramrdy = 1'b0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramrdy(ramrdy)
  );

  typedef struct packed {
    logic        wr;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] store;
  } acc_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] data;
  } cmp_t;

  acc_t exp_acc[$];
  cmp_t exp_cmp[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor: pops expectations when the DUT presents them
  logic mon_en = 1'b0;
  logic prev_strobe = 1'b0;
  logic m_strobe, m_icomp, m_dcomp;
  acc_t cur = '0;
  cmp_t cc;

  always @(negedge CLK) begin
    if (mon_en) begin
      m_strobe = ramREN | ramWEN;
      if (m_strobe && !prev_strobe) begin
        chkb("acc_expected", exp_acc.size() != 0, 1'b1);
        if (exp_acc.size() != 0) begin
          cur = exp_acc.pop_front();
          chk32("acc_addr", ramaddr, cur.addr);
          chkb("acc_wen", ramWEN, cur.wr);
          chkb("acc_ren", ramREN, !cur.wr);
          if (cur.wr) chk32("acc_store", ramstore, cur.store);
        end
      end else if (m_strobe) begin
        chk32("acc_addr_hold", ramaddr, cur.addr);
        chkb("acc_wen_hold", ramWEN, cur.wr);
        if (cur.wr) chk32("acc_store_hold", ramstore, cur.store);
      end
      prev_strobe = m_strobe;

      m_icomp = iREN && !iwait;
      m_dcomp = (dREN | dWEN) && !dwait;
      chkb("iwait_no_req", !iREN && iwait, 1'b0);
      chkb("dwait_no_req", !(dREN | dWEN) && dwait, 1'b0);
      chkb("single_completion", m_icomp && m_dcomp, 1'b0);
      if (m_icomp || m_dcomp) begin
        chkb("cmp_expected", exp_cmp.size() != 0, 1'b1);
        if (exp_cmp.size() != 0) begin
          cc = exp_cmp.pop_front();
          chkb("cmp_side", m_icomp, cc.instr);
          chk32("cmp_data", m_icomp ? iload : dload, cc.data);
        end
      end
      if (!m_icomp) chk32("iload_idle", iload, 32'd0);
      if (!m_dcomp) chk32("dload_idle", dload, 32'd0);
    end
  end

  // ---------------- stimulus, requesters and reference model
  int   p_req, p_rdy, p_rst, p_drop;
  logic force_wr;

  logic i_pend = 1'b0, d_pend = 1'b0;
  logic i_done = 1'b0, d_done = 1'b0;
  int   d_kind = 0;
  logic m_busy = 1'b0, m_side_i = 1'b0, m_wr = 1'b0;
  int   m_starve = 0;

  function automatic logic rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h40;
      1:       return 32'h100;
      2:       return 32'h200;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_cycle();
    logic dreq;
    @(posedge CLK);
    #1;
    if (i_done) i_pend = 1'b0;
    if (d_done) d_pend = 1'b0;
    i_done = 1'b0;
    d_done = 1'b0;

    if (!i_pend && !(m_busy && m_side_i) && rnd(p_req)) begin
      i_pend = 1'b1;
      iaddr  = pick_addr();
    end
    if (!d_pend && !(m_busy && !m_side_i) && rnd(p_req)) begin
      d_pend = 1'b1;
      d_kind = force_wr ? 1 : int'($urandom_range(0, 2));
      daddr  = pick_addr();
      dstore = force_wr ? 32'hDEADBEEF : $urandom;
    end
    if (m_busy && m_side_i && i_pend && rnd(p_drop)) i_pend = 1'b0;
    if (m_busy && !m_side_i && d_pend && rnd(p_drop)) d_pend = 1'b0;
    // Captured values must win over whatever the requester shows mid-access.
    if (m_busy && m_side_i) iaddr = $urandom;
    if (m_busy && !m_side_i) begin
      daddr  = $urandom;
      dstore = $urandom;
    end

    iREN    = i_pend;
    dREN    = d_pend && (d_kind != 1);
    dWEN    = d_pend && (d_kind != 0);
    ramrdy  = rnd(p_rdy);
    ramload = $urandom;
    RST     = rnd(p_rst);

    dreq = dREN | dWEN;
    if (RST) begin
      m_busy   = 1'b0;
      m_starve = 0;
    end else if (m_busy) begin
      if (ramrdy) begin
        if (m_side_i && iREN) begin
          exp_cmp.push_back('{instr: 1'b1, data: ramload});
          i_done = 1'b1;
        end else if (!m_side_i && dreq) begin
          exp_cmp.push_back('{instr: 1'b0, data: m_wr ? 32'd0 : ramload});
          d_done = 1'b1;
        end
        m_busy = 1'b0;
      end
    end else if (dreq && (m_starve < STARVE || !iREN)) begin
      exp_acc.push_back('{wr: dWEN, instr: 1'b0, addr: daddr, store: dstore});
      m_busy   = 1'b1;
      m_side_i = 1'b0;
      m_wr     = dWEN;
      m_starve = iREN ? ((m_starve + 1 > STARVE) ? STARVE : m_starve + 1) : 0;
    end else if (iREN) begin
      exp_acc.push_back('{wr: 1'b0, instr: 1'b1, addr: iaddr, store: 32'd0});
      m_busy   = 1'b1;
      m_side_i = 1'b1;
      m_wr     = 1'b0;
      m_starve = 0;
    end
  endtask

  task automatic phase(input int n, input int req, input int rdy, input int rst,
                       input int drop, input logic fw);
    p_req = req; p_rdy = rdy; p_rst = rst; p_drop = drop; force_wr = fw;
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    iREN = 1'b1;
    @(negedge CLK);
    chkb("rst_ramREN", ramREN, 1'b0);
    chkb("rst_ramWEN", ramWEN, 1'b0);
    chk32("rst_ramaddr", ramaddr, 32'd0);
    chk32("rst_ramstore", ramstore, 32'd0);
    chk32("rst_iload", iload, 32'd0);
    chk32("rst_dload", dload, 32'd0);
    chkb("rst_iwait", iwait, 1'b1);
    chkb("rst_dwait", dwait, 1'b0);
    @(posedge CLK);
    #1;
    iREN   = 1'b0;
    mon_en = 1'b1;

    phase(3000, 50, 60, 1, 6, 1'b0);   // mixed random traffic
    phase(300, 100, 100, 0, 0, 1'b0);  // saturated, fast RAM
    phase(300, 100, 100, 0, 0, 1'b1);  // continuous writes vs instruction
    phase(800, 60, 15, 0, 0, 1'b0);    // long RAM stalls
    phase(400, 70, 50, 2, 10, 1'b0);   // resets and drops under stalls
    phase(30, 0, 100, 0, 0, 1'b0);     // drain
    @(negedge CLK);
    #1;

    chkb("acc_queue_empty", exp_acc.size() == 0, 1'b1);
    chkb("cmp_queue_empty", exp_cmp.size() == 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL parameter: STARVE_MAX, default 4, max consecutive data grants while an instruction request waits.
REQ-002 SHALL port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL port: iREN  input  1  instruction read request (held until iwait low).
REQ-005 SHALL port: iaddr  input  32  instruction word address.
REQ-006 SHALL port: iwait  output  1  instruction stall; low only in instruction completion cycle.
REQ-007 SHALL port: iload  output  32  instruction read data.
REQ-008 SHALL port: dREN, dWEN  input  1 each  data read / write request (held until dwait low).
REQ-009 SHALL port: daddr, dstore  input  32 each  data address / write data.
REQ-010 SHALL port: dwait  output  1  data stall; low only in data completion cycle.
REQ-011 SHALL port: dload  output  32  data read data.
REQ-012 SHALL port: ramREN, ramWEN  output  1 each  RAM read / write strobe.
REQ-013 SHALL port: ramaddr, ramstore  output  32 each  RAM address / write data.
REQ-014 SHALL port: ramload  input  32  RAM read data; ramrdy  input  1  RAM access complete.

Function
REQ-015 SHALL implement FSM states IDLE, IACC, DACC; one RAM access in flight at most.
REQ-016 SHALL, in IDLE, select: data if (dREN|dWEN) and (starve_cnt<STARVE_MAX or !iREN); else instruction if iREN; else stay IDLE.
REQ-017 SHALL on grant capture address (and dstore, and write/read type) into registers, enter IACC/DACC next edge.
REQ-018 SHALL drive ramaddr/ramstore from captured registers only; ramREN=1 in IACC or DACC-read, ramWEN=1 in DACC-write; both 0 in IDLE.
REQ-019 SHALL treat dREN&dWEN simultaneously as write.
REQ-020 SHALL, in IACC with ramrdy=1: iwait=0, iload=ramload that cycle, next state IDLE.
REQ-021 SHALL, in DACC with ramrdy=1: dwait=0, dload=ramload (reads; 0 for writes), next state IDLE.
REQ-022 SHALL drive iwait=iREN and dwait=(dREN|dWEN) in all non-completion cycles; iload/dload=0 outside completion.
REQ-023 SHALL hold access state indefinitely while ramrdy=0 (no timeout).
REQ-024 SHALL give minimum latency: request in IDLE at cycle N -> strobe cycle N+1 -> completion cycle N+1 if ramrdy immediate; IDLE again N+2.
REQ-025 SHALL increment starve_cnt on each data grant made while iREN=1, saturating at STARVE_MAX.
REQ-026 SHALL clear starve_cnt on instruction grant, or on data grant with iREN=0.
REQ-027 SHALL finish an in-flight access even if requester drops its request; completion result discarded (no wait-low pulse to a non-requesting side).
REQ-028 SHALL ignore address/data changes from requesters during an access (captured values used).

Reset
REQ-029 SHALL on RST=1 at a rising edge: state=IDLE, starve_cnt=0, captured address/data=0.
REQ-030 SHALL drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0 while in reset state.
REQ-031 SHALL abort an in-flight access on reset mid-operation; strobes low from the cycle after the reset edge; no completion signalled.
REQ-032 SHALL produce iwait=iREN, dwait=(dREN|dWEN) immediately after reset.

Verification
REQ-033 SHALL test: iREN=1, iaddr=0x40, ramrdy=1 always -> ramREN=1, ramaddr=0x40 cycle N+1, iwait=0, iload=ramload same cycle.
REQ-034 SHALL test: iREN and dREN both at IDLE, daddr=0x100 -> DACC first, dwait=0 at completion, iwait stays 1 until subsequent IACC completes.
REQ-035 SHALL test: iREN held, continuous dWEN (dstore=0xDEADBEEF), STARVE_MAX=4 -> 4 data writes then one instruction grant, then starve_cnt=0.
REQ-036 SHALL test: ramrdy held 0 for 5 cycles in DACC read -> dwait=1 and ramREN=1 all 5 cycles, dload=ramload on 6th.
REQ-037 SHALL test: RST=1 during IACC -> next cycle ramREN=0, state IDLE, iwait=iREN, no iwait-low pulse.
REQ-038 SHALL test: daddr changed from 0x100 to 0x200 mid-DACC -> ramaddr stays 0x100 until completion.
